// File: rtl/demux_4_stream.sv
// Registered 1-to-4 stream demultiplexer with a small FIFO per destination.
// Optional per-destination accept counters are enabled with DEMUX_4_STATS_EN.
module demux_4_stream #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic [WIDTH-1:0] out3_data,
  output logic             out0_valid,
  output logic             out1_valid,
  output logic             out2_valid,
  output logic             out3_valid,
  input  logic             out0_ready,
  input  logic             out1_ready,
  input  logic             out2_ready,
  input  logic             out3_ready,
  output logic             busy
`ifdef DEMUX_4_STATS_EN
  ,
  input  logic             cnt_clear,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1,
  output logic [15:0]      cnt2,
  output logic [15:0]      cnt3
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [3:0]       valid;
  logic [3:0]       ready;
  logic [3:0]       full;
  logic [3:0]       push;
  logic [3:0]       pop;
  logic [WIDTH-1:0] head [4];

  assign ready = {out3_ready, out2_ready, out1_ready, out0_ready};

  // A full FIFO still accepts when its head is leaving in the same cycle.
  assign in_ready = !full[in_select] || pop[in_select];

  for (genvar g = 0; g < 4; g++) begin : gen_fifo
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;

    assign valid[g] = (count != '0);
    assign full[g]  = (count == FULL_CNT);
    assign pop[g]   = valid[g] && ready[g];
    assign push[g]  = in_valid && in_ready && (in_select == 2'(g));
    assign head[g]  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
        if (push[g]) begin
          mem[wr_ptr] <= in_data;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop[g]) rd_ptr <= rd_ptr + 1'b1;
        case ({push[g], pop[g]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  assign out0_data  = head[0];
  assign out1_data  = head[1];
  assign out2_data  = head[2];
  assign out3_data  = head[3];
  assign out0_valid = valid[0];
  assign out1_valid = valid[1];
  assign out2_valid = valid[2];
  assign out3_valid = valid[3];
  assign busy       = |valid;

`ifdef DEMUX_4_STATS_EN
  logic [15:0] cnt [4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < 4; n++) cnt[n] <= '0;
    end else if (cnt_clear) begin
      for (int n = 0; n < 4; n++) cnt[n] <= '0;
    end else begin
      for (int n = 0; n < 4; n++)
        if (push[n] && cnt[n] != 16'hFFFF) cnt[n] <= cnt[n] + 16'd1;
    end
  end

  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];
  assign cnt2 = cnt[2];
  assign cnt3 = cnt[3];
`endif

endmodule

// File: tb/tb_demux_4_stream.sv
// Self-checking bench for demux_4_stream: directed steps plus a random burst,
// checked every cycle against per-destination queues.
module tb_demux_4_stream;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] in_data;
  logic [1:0]  in_select;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out0_data, out1_data, out2_data, out3_data;
  logic        out0_valid, out1_valid, out2_valid, out3_valid;
  logic [3:0]  rdy;
  logic        busy;
`ifdef DEMUX_4_STATS_EN
  logic        cnt_clear;
  logic [15:0] cnt0, cnt1, cnt2, cnt3;
  int          exp_cnt [4];
`endif

  always #5 clk = ~clk;

  demux_4_stream #(.WIDTH(32), .DEPTH_LOG2(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_select(in_select), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out1_data(out1_data), .out2_data(out2_data), .out3_data(out3_data),
    .out0_valid(out0_valid), .out1_valid(out1_valid), .out2_valid(out2_valid), .out3_valid(out3_valid),
    .out0_ready(rdy[0]), .out1_ready(rdy[1]), .out2_ready(rdy[2]), .out3_ready(rdy[3]),
    .busy(busy)
`ifdef DEMUX_4_STATS_EN
    , .cnt_clear(cnt_clear), .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
`endif
  );

  logic [31:0] od [4];
  logic [3:0]  ov;
  assign od[0] = out0_data;
  assign od[1] = out1_data;
  assign od[2] = out2_data;
  assign od[3] = out3_data;
  assign ov    = {out3_valid, out2_valid, out1_valid, out0_valid};

  int          tests = 0;
  int          fails = 0;
  logic [31:0] q [4][$];
  int          seen [4];
  bit          acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Each destination holds at most 2 words; a full one accepts only if it pops.
  function automatic bit exp_ready();
    int s;
    s = int'(in_select);
    return (q[s].size() < 2) || (q[s].size() > 0 && rdy[s]);
  endfunction

  function automatic bit exp_busy();
    return (q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0;
  endfunction

  // Called just after a negedge with inputs driven; returns on the next negedge.
  task automatic tick(output bit accepted);
    #1;
    chk("in_ready", in_ready, exp_ready());
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("valid%0d", n), ov[n], q[n].size() != 0);
      if (q[n].size() != 0) chk($sformatf("data%0d", n), od[n], q[n][0]);
    end
    chk("busy", busy, exp_busy());
`ifdef DEMUX_4_STATS_EN
    chk("cnt0", cnt0, exp_cnt[0]);
    chk("cnt1", cnt1, exp_cnt[1]);
    chk("cnt2", cnt2, exp_cnt[2]);
    chk("cnt3", cnt3, exp_cnt[3]);
`endif
    accepted = in_valid && exp_ready();
    for (int n = 0; n < 4; n++) if (ov[n] && rdy[n]) seen[n]++;
    @(posedge clk);
    for (int n = 0; n < 4; n++)
      if (q[n].size() != 0 && rdy[n]) void'(q[n].pop_front());
    if (accepted) q[in_select].push_back(in_data);
`ifdef DEMUX_4_STATS_EN
    if (cnt_clear) for (int n = 0; n < 4; n++) exp_cnt[n] = 0;
    else if (accepted && exp_cnt[in_select] < 65535) exp_cnt[in_select]++;
`endif
    @(negedge clk);
  endtask

  initial begin
    int idx;
    int cyc;
    logic [31:0] words [400];

    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_data   = $urandom;
    in_select = 2'd0;
    rdy       = 4'hF;
    for (int n = 0; n < 4; n++) seen[n] = 0;
`ifdef DEMUX_4_STATS_EN
    cnt_clear = 1'b0;
    for (int n = 0; n < 4; n++) exp_cnt[n] = 0;
`endif

    // Reset held while the producer keeps offering words.
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      in_select = 2'(s);
      #1;
      chk("rst_in_ready", in_ready, 1);
      for (int n = 0; n < 4; n++) begin
        chk("rst_valid", ov[n], 0);
        chk("rst_data", od[n], 0);
      end
      chk("rst_busy", busy, 0);
    end
    @(negedge clk);
    reset_n  = 1'b1;
    in_valid = 1'b0;
    tick(acc);

    // Single dispatch to output 2.
    in_valid = 1'b1; in_select = 2'd2; in_data = 32'hDEADBEEF;
    tick(acc);
    chk("sd_acc", acc, 1);
    in_valid = 1'b0;
    #1;
    chk("sd_v2", out2_valid, 1);
    chk("sd_d2", out2_data, 32'hDEADBEEF);
    chk("sd_others", {out3_valid, out1_valid, out0_valid}, 0);
    tick(acc);
    #1 chk("sd_v2_drop", out2_valid, 0);

    // Full and stall on output 1.
    rdy = 4'b1101;
    in_valid = 1'b1; in_select = 2'd1;
    in_data = 32'hA1; tick(acc); chk("fs_a1", acc, 1);
    in_data = 32'hB2; tick(acc); chk("fs_b2", acc, 1);
    in_data = 32'hC3;
    #1 chk("fs_stall", in_ready, 0);
    tick(acc);
    in_select = 2'd0; in_data = 32'h0000D0D0;
    tick(acc); chk("fs_sel0", acc, 1);
    in_select = 2'd1; in_data = 32'hC3; rdy = 4'hF;
    #1;
    chk("fs_head_a1", out1_data, 32'hA1);
    chk("fs_c3_ready", in_ready, 1);
    tick(acc);
    in_valid = 1'b0;
    #1 chk("fs_head_b2", out1_data, 32'hB2);
    tick(acc);
    #1 chk("fs_head_c3", out1_data, 32'hC3);
    repeat (2) tick(acc);

    // Full FIFO 3 pushed and popped in the same cycle.
    rdy = 4'b0111;
    in_valid = 1'b1; in_select = 2'd3;
    in_data = 32'h11110001; tick(acc);
    in_data = 32'h11110002; tick(acc);
    in_data = 32'h11110003; rdy = 4'hF;
    #1 chk("fp_ready", in_ready, 1);
    tick(acc);
    in_valid = 1'b0; rdy = 4'b0111;
    #1;
    chk("fp_v3", out3_valid, 1);
    chk("fp_d3", out3_data, 32'h11110002);
    tick(acc);
    rdy = 4'hF;
    tick(acc);
    #1 chk("fp_last", out3_data, 32'h11110003);
    repeat (2) tick(acc);
    #1 chk("fp_empty", out3_valid, 0);

    // Asynchronous reset in the middle of buffered traffic.
    rdy = 4'h0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_select = 2'(i % 2); in_data = $urandom; tick(acc);
    end
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_valid", {28'd0, ov}, 0);
    for (int n = 0; n < 4; n++) q[n].delete();
`ifdef DEMUX_4_STATS_EN
    for (int n = 0; n < 4; n++) exp_cnt[n] = 0;
`endif
    @(negedge clk);
    reset_n = 1'b1; rdy = 4'hF;
    tick(acc);

    // Round-robin burst with random back-pressure.
    for (int i = 0; i < 400; i++) words[i] = $urandom;
    for (int n = 0; n < 4; n++) seen[n] = 0;
    idx = 0; cyc = 0;
    while (idx < 400 && cyc < 5000) begin
      in_valid  = 1'b1;
      in_select = 2'(idx % 4);
      in_data   = words[idx];
      rdy       = 4'($urandom);
      tick(acc);
      if (acc) idx++;
      cyc++;
    end
    chk("rr_sent", idx, 400);
    in_valid = 1'b0; rdy = 4'hF;
    repeat (4) tick(acc);
    for (int n = 0; n < 4; n++) chk($sformatf("rr_seen%0d", n), seen[n], 100);
    #1 chk("rr_idle", busy, 0);

`ifdef DEMUX_4_STATS_EN
    cnt_clear = 1'b1; tick(acc); cnt_clear = 1'b0;
    in_valid = 1'b1;
    in_select = 2'd0;
    repeat (5) begin in_data = $urandom; tick(acc); end
    in_select = 2'd2;
    repeat (3) begin in_data = $urandom; tick(acc); end
    in_valid = 1'b0;
    #1;
    chk("st_cnt0", cnt0, 5);
    chk("st_cnt2", cnt2, 3);
    in_valid = 1'b1; in_select = 2'd1; cnt_clear = 1'b1;
    tick(acc);
    in_valid = 1'b0; cnt_clear = 1'b0;
    #1 chk("st_clear", {cnt3, cnt2, cnt1, cnt0}, 0);
    chk("st_clear_hi", {cnt3, cnt2}, 0);
    repeat (2) tick(acc);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
